// File: rtl/div_result_buffer.sv
// Result FIFO behind the non-stallable pipelined divider. Reorders nothing; it only buffers
// results and grants issue credits so the divider can never overrun the FIFO.
module div_result_buffer #(
  parameter int unsigned QUOTIENT_WIDTH = 8,
  parameter int unsigned REMINDER_WIDTH = 8,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      issue_i,
  output logic                      can_issue_o,
  input  logic                      valid_i,
  input  logic [QUOTIENT_WIDTH-1:0] quotient_i,
  input  logic [REMINDER_WIDTH-1:0] reminder_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [QUOTIENT_WIDTH-1:0] quotient_o,
  output logic [REMINDER_WIDTH-1:0] reminder_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned InfW = PtrW + 2;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [InfW-1:0] InfMax  = '1;

  logic [PtrW-1:0]           r_wr_ptr;
  logic [PtrW-1:0]           r_rd_ptr;
  logic [LvlW-1:0]           r_level;
  logic [InfW-1:0]           r_inflight;
  logic                      r_overflow;
  logic [QUOTIENT_WIDTH-1:0] r_q_mem [DEPTH];
  logic [REMINDER_WIDTH-1:0] r_r_mem [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [LvlW-1:0] w_level_d;
  logic [InfW-1:0] w_inflight_d;
  logic [InfW:0]   w_reserved;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LvlFull);
  assign w_pop   = !w_empty && ready_i;
  // At full, a same-cycle pop frees the slot that wr_ptr (== rd_ptr) is about to overwrite.
  assign w_push  = valid_i && (!w_full || w_pop);
  assign w_drop  = valid_i && w_full && !w_pop;

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LvlW'(1);
      2'b01:   w_level_d = r_level - LvlW'(1);
      default: w_level_d = r_level;
    endcase
  end

  // Saturating credit counter; results with nothing outstanding do not underflow it.
  always_comb begin
    w_inflight_d = r_inflight;
    unique case ({issue_i, valid_i})
      2'b10:   if (r_inflight != InfMax) w_inflight_d = r_inflight + InfW'(1);
      2'b01:   if (r_inflight != '0) w_inflight_d = r_inflight - InfW'(1);
      default: w_inflight_d = r_inflight;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_level    <= w_level_d;
      r_inflight <= w_inflight_d;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_mem[r_wr_ptr] <= quotient_i;
      r_r_mem[r_wr_ptr] <= reminder_i;
    end
  end

  assign w_reserved  = {1'b0, r_inflight} + (InfW + 1)'(r_level);
  assign can_issue_o = (w_reserved < (InfW + 1)'(DEPTH));
  assign valid_o     = !w_empty;
  assign quotient_o  = w_empty ? '0 : r_q_mem[r_rd_ptr];
  assign reminder_o  = w_empty ? '0 : r_r_mem[r_rd_ptr];
  assign level_o     = r_level;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_div_result_buffer.sv
// Randomised bench for div_result_buffer against a queue-based reference model and a
// latency-8 divider model.
module tb_div_result_buffer;

  localparam int unsigned QW    = 8;
  localparam int unsigned RW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int          IMAX  = 4 * DEPTH - 1;
  localparam int          LAT   = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          issue_i = 1'b0;
  logic          can_issue_o;
  logic          valid_i = 1'b0;
  logic [QW-1:0] quotient_i = '0;
  logic [RW-1:0] reminder_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [QW-1:0] quotient_o;
  logic [RW-1:0] reminder_o;
  logic [3:0]    level_o;
  logic          overflow_o;

  div_result_buffer #(
    .QUOTIENT_WIDTH(QW),
    .REMINDER_WIDTH(RW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .issue_i    (issue_i),
    .can_issue_o(can_issue_o),
    .valid_i    (valid_i),
    .quotient_i (quotient_i),
    .reminder_i (reminder_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .quotient_o (quotient_o),
    .reminder_o (reminder_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents in order, outstanding divisions, sticky drop flag.
  logic [15:0] m_q[$];
  int          m_inflight = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] golden[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = m_q.size();
    check_eq("valid", 32'(valid_o), 32'(lvl != 0));
    check_eq("level", 32'(level_o), 32'(lvl));
    check_eq("can_issue", 32'(can_issue_o), 32'((lvl + m_inflight) < DEPTH));
    check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
    if (lvl != 0) begin
      check_eq("quotient", 32'(quotient_o), 32'(m_q[0][15:8]));
      check_eq("reminder", 32'(reminder_o), 32'(m_q[0][7:0]));
    end
  endtask

  task automatic model_update(input bit iss, input bit vld, input logic [7:0] q,
                              input logic [7:0] r, input bit rdy);
    bit pop;
    bit full;
    pop  = (m_q.size() != 0) && rdy;
    full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (vld) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_q.push_back({q, r});
    end
    if (iss && !vld && m_inflight < IMAX) m_inflight++;
    else if (vld && !iss && m_inflight > 0) m_inflight--;
  endtask

  // Called one time unit after a rising edge; returns at the same phase of the next cycle.
  task automatic cycle(input bit iss, input bit vld, input logic [7:0] q, input logic [7:0] r,
                       input bit rdy);
    check_outputs();
    issue_i    = iss;
    valid_i    = vld;
    quotient_i = q;
    reminder_i = r;
    ready_i    = rdy;
    @(posedge clk_i);
    model_update(iss, vld, q, r, rdy);
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic reset_mid();
    issue_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    m_q.delete();
    m_inflight = 0;
    m_ovf = 1'b0;
    check_outputs();
    check_eq("rst_quotient", 32'(quotient_o), 32'd0);
    check_eq("rst_reminder", 32'(reminder_o), 32'd0);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0] pipe_a [LAT];
    logic [7:0] pipe_b [LAT];
    bit         pipe_v [LAT];
    int         pops;
    int         cyc;
    bit         iss, rdy, vld;
    logic [7:0] a, b, oq, orr;

    #3;
    check_outputs();
    check_eq("por_quotient", 32'(quotient_o), 32'd0);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset mid-stream with three entries stored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(i + 1), 8'(i), 1'b0);
    check_eq("pre_reset_level", 32'(level_o), 32'd3);
    reset_mid();

    // Ordering with ready high.
    cycle(1'b0, 1'b1, 8'd7, 8'd1, 1'b1);
    cycle(1'b0, 1'b1, 8'd12, 8'd0, 1'b1);
    cycle(1'b0, 1'b1, 8'd255, 8'd3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);

    // Credits exhausted by issues alone, then by stored results.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check_eq("credit_exhausted", 32'(can_issue_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    check_eq("full_level", 32'(level_o), 32'(DEPTH));
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check_eq("credit_back", 32'(can_issue_o), 32'd1);

    // Overflow: refill, then push into a full FIFO with no pop.
    cycle(1'b0, 1'b1, 8'd100, 8'd5, 1'b0);
    cycle(1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
    check_eq("overflow_set", 32'(overflow_o), 32'd1);
    check_eq("overflow_level", 32'(level_o), 32'(DEPTH));
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check_eq("overflow_sticky", 32'(overflow_o), 32'd1);
    reset_mid();

    // Push and pop together at full; 20 cycles wraps both pointers twice.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    check_eq("full_pushpop_level", 32'(level_o), 32'(DEPTH));
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    reset_mid();

    // Random traffic through a latency-8 divider model, issue gated by the credit rule.
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
      pipe_b[i] = 8'd1;
    end
    pops = 0;
    cyc  = 0;
    while (pops < 1000 && cyc < 20000) begin
      vld = pipe_v[LAT-1];
      oq  = pipe_a[LAT-1] / pipe_b[LAT-1];
      orr = pipe_a[LAT-1] % pipe_b[LAT-1];
      iss = ((m_q.size() + m_inflight) < DEPTH) && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 1) == 1);
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_a[i] = pipe_a[i-1];
        pipe_b[i] = pipe_b[i-1];
      end
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      pipe_v[0] = iss;
      pipe_a[0] = a;
      pipe_b[0] = b;
      if (iss) golden.push_back({a / b, a % b});
      if (valid_o && rdy) begin
        if (golden.size() == 0) begin
          check_eq("golden_underrun", 32'd1, 32'd0);
        end else begin
          check_eq("golden", {16'd0, quotient_o, reminder_o}, {16'd0, golden[0]});
          void'(golden.pop_front());
        end
        pops++;
      end
      cycle(iss, vld, oq, orr, rdy);
      cyc++;
    end
    check_eq("random_done", 32'(pops), 32'd1000);
    check_eq("random_no_overflow", 32'(overflow_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
